// File: rtl/id_ex_stage_pkg.sv
// Shared CPU definitions used by the ID/EX pipeline register and its hazard logic.
package id_ex_stage_pkg;

  // X31 is the zero register and never receives a write.
  localparam logic [4:0] ZERO_REG = 5'd31;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_ORR   = 3'd3,
    ALU_EOR   = 3'd4,
    ALU_LSL   = 3'd5,
    ALU_LSR   = 3'd6,
    ALU_PASSB = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic    RegWrite;
    logic    MemRead;
    logic    MemWrite;
    logic    MemToReg;
    logic    ALUSrc;
    alu_op_e ALUOp;
  } ex_ctrl_t;

  // Control word of an inserted bubble: nothing writes, nothing touches memory.
  localparam ex_ctrl_t CTRL_BUBBLE = '{
    RegWrite: 1'b0,
    MemRead:  1'b0,
    MemWrite: 1'b0,
    MemToReg: 1'b0,
    ALUSrc:   1'b0,
    ALUOp:    ALU_ADD
  };

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs and EX-side registered outputs of the ID/EX pipeline register.
interface id_ex_stage_if;

  logic        id_valid;
  logic [4:0]  id_regA;
  logic [4:0]  id_regB;
  logic        id_useB;
  logic [4:0]  id_Rd;
  logic        id_RegWrite;
  logic        id_MemRead;
  logic        id_MemWrite;
  logic        id_MemToReg;
  logic        id_ALUSrc;
  logic [2:0]  id_ALUOp;
  logic [63:0] id_readA;
  logic [63:0] id_readB;
  logic [63:0] id_imm;

  logic        ex_valid;
  logic [4:0]  ex_regA;
  logic [4:0]  ex_regB;
  logic [4:0]  ex_Rd;
  logic        ex_RegWrite;
  logic        ex_MemRead;
  logic        ex_MemWrite;
  logic        ex_MemToReg;
  logic        ex_ALUSrc;
  logic [2:0]  ex_ALUOp;
  logic [63:0] ex_readA;
  logic [63:0] ex_readB;
  logic [63:0] ex_imm;

  // Decode stage view: drives the id_* bundle, observes the ex_* bundle.
  modport master (
    output id_valid, id_regA, id_regB, id_useB, id_Rd,
           id_RegWrite, id_MemRead, id_MemWrite, id_MemToReg, id_ALUSrc, id_ALUOp,
           id_readA, id_readB, id_imm,
    input  ex_valid, ex_regA, ex_regB, ex_Rd,
           ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg, ex_ALUSrc, ex_ALUOp,
           ex_readA, ex_readB, ex_imm
  );

  // Pipeline register view: consumes id_*, produces ex_*.
  modport slave (
    input  id_valid, id_regA, id_regB, id_useB, id_Rd,
           id_RegWrite, id_MemRead, id_MemWrite, id_MemToReg, id_ALUSrc, id_ALUOp,
           id_readA, id_readB, id_imm,
    output ex_valid, ex_regA, ex_regB, ex_Rd,
           ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg, ex_ALUSrc, ex_ALUOp,
           ex_readA, ex_readB, ex_imm
  );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is read
// by the valid instruction in decode needs one bubble; a flush cancels the need.
module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_MemRead,
  input  logic [4:0] ex_Rd,
  input  logic       id_valid,
  input  logic [4:0] id_regA,
  input  logic [4:0] id_regB,
  input  logic       id_useB,
  input  logic       flush,
  output logic       stall
);

  logic w_loadInEx;
  logic w_matchA;
  logic w_matchB;

  assign w_loadInEx = ex_valid && ex_MemRead && (ex_Rd != ZERO_REG);
  assign w_matchA   = (ex_Rd == id_regA);
  assign w_matchB   = id_useB && (ex_Rd == id_regB);
  assign stall      = w_loadInEx && (w_matchA || w_matchB) && id_valid && !flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating
// count of the bubbles inserted.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  output logic         stall,
  output logic [15:0]  stall_count,
  id_ex_stage_if.slave pipe
);

  logic        w_hazard;
  ex_ctrl_t    w_idCtrl;

  logic        r_valid;
  ex_ctrl_t    r_ctrl;
  logic [4:0]  r_regA;
  logic [4:0]  r_regB;
  logic [4:0]  r_Rd;
  logic [63:0] r_readA;
  logic [63:0] r_readB;
  logic [63:0] r_imm;
  logic [15:0] r_stall_count;

  load_use_detect u_detect (
    .ex_valid   (r_valid),
    .ex_MemRead (r_ctrl.MemRead),
    .ex_Rd      (r_Rd),
    .id_valid   (pipe.id_valid),
    .id_regA    (pipe.id_regA),
    .id_regB    (pipe.id_regB),
    .id_useB    (pipe.id_useB),
    .flush      (flush),
    .stall      (w_hazard)
  );

  assign stall = w_hazard && !reset;

  // Decode control word, gated to a bubble when decode holds no valid instruction.
  always_comb begin
    w_idCtrl = CTRL_BUBBLE;
    if (pipe.id_valid) begin
      w_idCtrl.RegWrite = pipe.id_RegWrite && (pipe.id_Rd != ZERO_REG);
      w_idCtrl.MemRead  = pipe.id_MemRead;
      w_idCtrl.MemWrite = pipe.id_MemWrite;
      w_idCtrl.MemToReg = pipe.id_MemToReg;
      w_idCtrl.ALUSrc   = pipe.id_ALUSrc;
      w_idCtrl.ALUOp    = alu_op_e'(pipe.id_ALUOp);
    end
  end

  // Pipeline register and bubble counter; reset wins over flush, flush over stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid       <= 1'b0;
      r_ctrl        <= CTRL_BUBBLE;
      r_regA        <= 5'd0;
      r_regB        <= 5'd0;
      r_Rd          <= 5'd0;
      r_readA       <= 64'd0;
      r_readB       <= 64'd0;
      r_imm         <= 64'd0;
      r_stall_count <= 16'd0;
    end else begin
      r_regA  <= pipe.id_regA;
      r_regB  <= pipe.id_regB;
      r_Rd    <= pipe.id_Rd;
      r_readA <= pipe.id_readA;
      r_readB <= pipe.id_readB;
      r_imm   <= pipe.id_imm;
      if (flush || stall) begin
        r_valid <= 1'b0;
        r_ctrl  <= CTRL_BUBBLE;
      end else begin
        r_valid <= pipe.id_valid;
        r_ctrl  <= w_idCtrl;
      end
      if (stall && !flush && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign pipe.ex_valid    = r_valid;
  assign pipe.ex_regA     = r_regA;
  assign pipe.ex_regB     = r_regB;
  assign pipe.ex_Rd       = r_Rd;
  assign pipe.ex_RegWrite = r_ctrl.RegWrite;
  assign pipe.ex_MemRead  = r_ctrl.MemRead;
  assign pipe.ex_MemWrite = r_ctrl.MemWrite;
  assign pipe.ex_MemToReg = r_ctrl.MemToReg;
  assign pipe.ex_ALUSrc   = r_ctrl.ALUSrc;
  assign pipe.ex_ALUOp    = r_ctrl.ALUOp;
  assign pipe.ex_readA    = r_readA;
  assign pipe.ex_readB    = r_readB;
  assign pipe.ex_imm      = r_imm;
  assign stall_count      = r_stall_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for the ID/EX pipeline register: a table of instruction vectors
// with hand-computed results, then saturation and reset-mid-stall sequences.
module tb_id_ex_stage;

  typedef struct {
    logic        valid;
    logic [4:0]  regA;
    logic [4:0]  regB;
    logic        useB;
    logic [4:0]  Rd;
    logic [4:0]  ctrl;
    logic [2:0]  op;
    logic [63:0] readA;
    logic [63:0] readB;
    logic [63:0] imm;
    logic        flush;
    logic        expStall;
    logic        expValid;
    logic [2:0]  expCtrl;
    logic [15:0] expCount;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        stall;
  logic [15:0] stall_count;
  int          errors = 0;
  int          checks = 0;
  vec_t        vecs[$];
  vec_t        idle;
  vec_t        ldur5;
  vec_t        use5;

  id_ex_stage_if pipe ();

  id_ex_stage dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .stall       (stall),
    .stall_count (stall_count),
    .pipe        (pipe.slave)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Upper bound on simulation time so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got still running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // ctrl packs {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc}; expCtrl packs {RegWrite, MemRead, MemWrite}.
  function automatic vec_t mkVec(input logic valid, input logic [4:0] regA, input logic [4:0] regB,
                                 input logic useB, input logic [4:0] rd, input logic [4:0] ctrl,
                                 input logic [2:0] op, input logic [63:0] rA, input logic [63:0] rB,
                                 input logic [63:0] imm, input logic fl, input logic eStall,
                                 input logic eValid, input logic [2:0] eCtrl, input logic [15:0] eCount);
    vec_t v;
    v.valid = valid;  v.regA = regA;  v.regB = regB;  v.useB = useB;  v.Rd = rd;
    v.ctrl = ctrl;    v.op = op;      v.readA = rA;   v.readB = rB;   v.imm = imm;
    v.flush = fl;     v.expStall = eStall;  v.expValid = eValid;
    v.expCtrl = eCtrl;  v.expCount = eCount;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    pipe.id_valid    = v.valid;
    pipe.id_regA     = v.regA;
    pipe.id_regB     = v.regB;
    pipe.id_useB     = v.useB;
    pipe.id_Rd       = v.Rd;
    pipe.id_RegWrite = v.ctrl[4];
    pipe.id_MemRead  = v.ctrl[3];
    pipe.id_MemWrite = v.ctrl[2];
    pipe.id_MemToReg = v.ctrl[1];
    pipe.id_ALUSrc   = v.ctrl[0];
    pipe.id_ALUOp    = v.op;
    pipe.id_readA    = v.readA;
    pipe.id_readB    = v.readB;
    pipe.id_imm      = v.imm;
    flush            = v.flush;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    idle  = mkVec(0, 5'd0, 5'd0, 0, 5'd0, 5'b00000, 3'd0, 64'h0, 64'h0, 64'h0, 0, 0, 0, 3'b000, 16'd0);
    ldur5 = mkVec(1, 5'd1, 5'd0, 0, 5'd5, 5'b11011, 3'd0, 64'hAAAA, 64'h0, 64'h8, 0, 0, 1, 3'b110, 16'd0);
    use5  = mkVec(1, 5'd5, 5'd2, 1, 5'd6, 5'b10000, 3'd1, 64'h1, 64'h2, 64'h0, 0, 1, 0, 3'b000, 16'd0);

    // Plain ADD X3 = X1 + X2 passes straight through.
    vecs.push_back(mkVec(1, 5'd1,  5'd2, 1, 5'd3,  5'b10000, 3'd0, 64'h10,  64'h20, 64'h0,  0, 0, 1, 3'b100, 16'd0));
    // LDUR X5 enters EX.
    vecs.push_back(mkVec(1, 5'd1,  5'd0, 0, 5'd5,  5'b11011, 3'd0, 64'h100, 64'h0,  64'h8,  0, 0, 1, 3'b110, 16'd0));
    // SUB reading X5 on A: one bubble, counter 0 -> 1.
    vecs.push_back(mkVec(1, 5'd5,  5'd2, 1, 5'd6,  5'b10000, 3'd1, 64'h55,  64'h66, 64'h0,  0, 1, 0, 3'b000, 16'd1));
    // Same SUB retried: load gone from EX, so it passes.
    vecs.push_back(mkVec(1, 5'd5,  5'd2, 1, 5'd6,  5'b10000, 3'd1, 64'h55,  64'h66, 64'h0,  0, 0, 1, 3'b100, 16'd1));
    // LDUR targeting X31: RegWrite suppressed.
    vecs.push_back(mkVec(1, 5'd2,  5'd0, 0, 5'd31, 5'b11011, 3'd0, 64'h1,   64'h2,  64'h10, 0, 0, 1, 3'b010, 16'd1));
    // Reader of X31 after a load to X31: no stall.
    vecs.push_back(mkVec(1, 5'd31, 5'd0, 0, 5'd4,  5'b10001, 3'd0, 64'h3,   64'h4,  64'h5,  0, 0, 1, 3'b100, 16'd1));
    // LDUR X7.
    vecs.push_back(mkVec(1, 5'd1,  5'd0, 0, 5'd7,  5'b11011, 3'd0, 64'h7,   64'h8,  64'h18, 0, 0, 1, 3'b110, 16'd1));
    // regB = 7 but not used: no stall.
    vecs.push_back(mkVec(1, 5'd2,  5'd7, 0, 5'd8,  5'b10001, 3'd3, 64'h9,   64'hA,  64'hB,  0, 0, 1, 3'b100, 16'd1));
    // LDUR X7 again.
    vecs.push_back(mkVec(1, 5'd1,  5'd0, 0, 5'd7,  5'b11011, 3'd0, 64'h7,   64'h8,  64'h18, 0, 0, 1, 3'b110, 16'd1));
    // STUR reading X7 on B: stall, counter 1 -> 2.
    vecs.push_back(mkVec(1, 5'd2,  5'd7, 1, 5'd0,  5'b00101, 3'd0, 64'hC,   64'hD,  64'h20, 0, 1, 0, 3'b000, 16'd2));
    // STUR retried: passes with MemWrite.
    vecs.push_back(mkVec(1, 5'd2,  5'd7, 1, 5'd0,  5'b00101, 3'd0, 64'hC,   64'hD,  64'h20, 0, 0, 1, 3'b001, 16'd2));
    // Invalid decode slot carrying control bits: gated to a bubble.
    vecs.push_back(mkVec(0, 5'd1,  5'd2, 0, 5'd9,  5'b11100, 3'd0, 64'h0,   64'h0,  64'h0,  0, 0, 0, 3'b000, 16'd2));
    // LDUR X9.
    vecs.push_back(mkVec(1, 5'd1,  5'd0, 0, 5'd9,  5'b11011, 3'd0, 64'h1,   64'h0,  64'h4,  0, 0, 1, 3'b110, 16'd2));
    // Load-use together with flush: no stall, bubble, counter unchanged.
    vecs.push_back(mkVec(1, 5'd9,  5'd2, 1, 5'd10, 5'b10000, 3'd0, 64'h1,   64'h2,  64'h0,  1, 0, 0, 3'b000, 16'd2));
    // LDUR X10.
    vecs.push_back(mkVec(1, 5'd1,  5'd0, 0, 5'd10, 5'b11011, 3'd0, 64'h2,   64'h0,  64'h4,  0, 0, 1, 3'b110, 16'd2));
    // Matching register but invalid decode slot: no stall.
    vecs.push_back(mkVec(0, 5'd10, 5'd0, 0, 5'd11, 5'b10000, 3'd0, 64'h0,   64'h0,  64'h0,  0, 0, 0, 3'b000, 16'd2));
    // Independent instruction with ALUOp 7.
    vecs.push_back(mkVec(1, 5'd3,  5'd4, 1, 5'd12, 5'b10000, 3'd7, 64'hDEAD_BEEF_0000_0001, 64'h1234, 64'h0, 0, 0, 1, 3'b100, 16'd2));

    // Reset state, including stall held low while reset is high.
    reset = 1'b1;
    applyStimulus(idle);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_valid", pipe.ex_valid, 1'b0);
    checkOutput("rst_regwrite", pipe.ex_RegWrite, 1'b0);
    checkOutput("rst_memread", pipe.ex_MemRead, 1'b0);
    checkOutput("rst_rd", pipe.ex_Rd, 5'd0);
    checkOutput("rst_readA", pipe.ex_readA, 64'd0);
    checkOutput("rst_count", stall_count, 16'd0);
    checkOutput("rst_stall", stall, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_stall", i), stall, vecs[i].expStall);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_valid", i), pipe.ex_valid, vecs[i].expValid);
      checkOutput($sformatf("v%0d_regwrite", i), pipe.ex_RegWrite, vecs[i].expCtrl[2]);
      checkOutput($sformatf("v%0d_memread", i), pipe.ex_MemRead, vecs[i].expCtrl[1]);
      checkOutput($sformatf("v%0d_memwrite", i), pipe.ex_MemWrite, vecs[i].expCtrl[0]);
      checkOutput($sformatf("v%0d_count", i), stall_count, vecs[i].expCount);
      if (vecs[i].expValid) begin
        checkOutput($sformatf("v%0d_rd", i), pipe.ex_Rd, vecs[i].Rd);
        checkOutput($sformatf("v%0d_regA", i), pipe.ex_regA, vecs[i].regA);
        checkOutput($sformatf("v%0d_regB", i), pipe.ex_regB, vecs[i].regB);
        checkOutput($sformatf("v%0d_memtoreg", i), pipe.ex_MemToReg, vecs[i].ctrl[1]);
        checkOutput($sformatf("v%0d_alusrc", i), pipe.ex_ALUSrc, vecs[i].ctrl[0]);
        checkOutput($sformatf("v%0d_aluop", i), pipe.ex_ALUOp, vecs[i].op);
        checkOutput($sformatf("v%0d_readA", i), pipe.ex_readA, vecs[i].readA);
        checkOutput($sformatf("v%0d_readB", i), pipe.ex_readB, vecs[i].readB);
        checkOutput($sformatf("v%0d_imm", i), pipe.ex_imm, vecs[i].imm);
      end
    end

    // Saturation: preload the counter near the top, then 100 load-use pairs.
    @(negedge clk);
    applyStimulus(idle);
    force dut.r_stall_count = 16'hFFA0;
    @(posedge clk);
    @(negedge clk);
    release dut.r_stall_count;
    #1;
    checkOutput("sat_preload", stall_count, 16'hFFA0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      applyStimulus(ldur5);
      @(posedge clk);
      @(negedge clk);
      applyStimulus(use5);
      #1;
      if (i == 0) checkOutput("sat_stall", stall, 1'b1);
      @(posedge clk);
      #1;
      if (i == 49) checkOutput("sat_mid_count", stall_count, 16'hFFD2);
      if (i == 94) checkOutput("sat_reach_count", stall_count, 16'hFFFF);
    end
    checkOutput("sat_hold_count", stall_count, 16'hFFFF);
    checkOutput("sat_bubble_valid", pipe.ex_valid, 1'b0);

    // Reset arriving during a stall cycle clears everything on the next edge.
    @(negedge clk);
    applyStimulus(ldur5);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(use5);
    #1;
    checkOutput("rms_stall_before", stall, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("rms_stall_in_reset", stall, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("rms_valid", pipe.ex_valid, 1'b0);
    checkOutput("rms_regwrite", pipe.ex_RegWrite, 1'b0);
    checkOutput("rms_memread", pipe.ex_MemRead, 1'b0);
    checkOutput("rms_memwrite", pipe.ex_MemWrite, 1'b0);
    checkOutput("rms_rd", pipe.ex_Rd, 5'd0);
    checkOutput("rms_regA", pipe.ex_regA, 5'd0);
    checkOutput("rms_readA", pipe.ex_readA, 64'd0);
    checkOutput("rms_imm", pipe.ex_imm, 64'd0);
    checkOutput("rms_count", stall_count, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(idle);
    @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk input 1 -- the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset input 1 -- synchronous reset, active-high.
REQ-003 SHALL have ports id_valid input 1, id_regA input 5, id_regB input 5, id_useB input 1, id_Rd input 5 -- decode-stage instruction validity, source registers, whether regB is read, and destination register.
REQ-004 SHALL have ports id_RegWrite, id_MemRead, id_MemWrite, id_MemToReg, id_ALUSrc input 1 each, and id_ALUOp input 3 -- decode control bits.
REQ-005 SHALL have ports id_readA, id_readB, id_imm input 64 each -- register-file data and the sign-extended immediate.
REQ-006 SHALL have port flush input 1 -- taken branch resolved downstream; squashes the instruction in decode.
REQ-007 SHALL have outputs ex_valid 1, ex_regA 5, ex_regB 5, ex_Rd 5, ex_RegWrite 1, ex_MemRead 1, ex_MemWrite 1, ex_MemToReg 1, ex_ALUSrc 1, ex_ALUOp 3, ex_readA 64, ex_readB 64, ex_imm 64 -- the registered EX-stage bundle; ex_regA, ex_regB, ex_MemWrite and the downstream Rd/RegWrite feed the forwarding unit.
REQ-008 SHALL have output stall 1 -- holds the PC and the IF/ID register this cycle.
REQ-009 SHALL have output stall_count 16 -- saturating count of load-use bubbles inserted.

Function
REQ-010 SHALL assert stall combinationally when ex_valid and ex_MemRead are 1, ex_Rd is not 31, and either ex_Rd equals id_regA, or id_useB is 1 and ex_Rd equals id_regB, and id_valid is 1.
REQ-011 SHALL deassert stall whenever flush is 1, because flush has priority over stall.
REQ-012 SHALL, on a clock edge with flush = 1, load a bubble: ex_valid, ex_RegWrite, ex_MemRead and ex_MemWrite = 0; all other fields are don't-care.
REQ-013 SHALL, on a clock edge with stall = 1 and flush = 0, load the same bubble as REQ-012.
REQ-014 SHALL, on any other clock edge, register every id_* field into the matching ex_* field, with latency exactly 1 cycle.
REQ-015 SHALL gate the registered control bits with id_valid, so that id_valid = 0 yields the bubble values of REQ-012.
REQ-016 SHALL force ex_RegWrite to 0 when id_Rd is 31, because X31 is never written.
REQ-017 SHALL produce at most one bubble per load-use pair; the cycle after a bubble has ex_MemRead = 0, so stall falls automatically.
REQ-018 SHALL increment stall_count by 1 on each edge where stall = 1 and flush = 0, and SHALL hold it at 16'hFFFF once reached, with no wrap.

Reset
REQ-019 SHALL, on a clock edge with reset = 1, set all ex_* control bits and ex_valid to 0, all ex_* data and register fields to 0, and stall_count to 0.
REQ-020 SHALL give reset priority over flush and stall; a reset mid-stall discards the stalled instruction's bubble state.
REQ-021 SHALL hold stall at 0 during the cycle that reset is high.

Structure
REQ-022 SHALL take the 3-bit ALUOp encoding, the constant ZERO_REG = 5'd31 and a packed ex_ctrl_t typedef (RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, ALUOp) from the shared cpu package.
REQ-023 SHALL contain one sub-module, load_use_detect, which is combinational and implements REQ-010 and REQ-011; the pipeline register and counter stay in id_ex_stage.

Verification
REQ-024 SHALL cover the plain pass-through case: after reset, ADD with id_regA = 1, id_regB = 2, id_Rd = 3 and id_RegWrite = 1 appears one cycle later with ex_Rd = 3 and ex_RegWrite = 1, and stall stays 0.
REQ-025 SHALL cover load-use on A: with ex holding LDUR ex_Rd = 5 and ex_MemRead = 1, and id_regA = 5, stall = 1 for exactly one cycle, the next ex_valid = 0, and stall_count goes 0 -> 1.
REQ-026 SHALL cover X31 and useB: ex_Rd = 31 with MemRead and id_regA = 31 gives stall = 0; ex_Rd = 7 with id_regB = 7 and id_useB = 0 gives stall = 0, while id_useB = 1 gives stall = 1.
REQ-027 SHALL cover flush versus stall: a load-use condition together with flush = 1 gives stall = 0 and a bubble next cycle, and stall_count is unchanged.
REQ-028 SHALL cover saturation: preload 100 consecutive stall events after forcing the count near 16'hFFFF, and the count holds at 16'hFFFF.
REQ-029 SHALL cover reset mid-stall: reset = 1 during a stall cycle clears all outputs and stall_count to 0 on the next edge.
